// File: rtl/vscale_dmem_arbiter_pkg.sv
// Shared constants for the vscale data-memory arbiter: datapath width,
// memory-type encodings, core-index width, default RAM depth, and the
// byte-lane helpers used by the response stage.
package vscale_dmem_arbiter_pkg;

  localparam int XPR_LEN        = 32;
  localparam int MEM_TYPE_WIDTH = 3;

  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_SB  = 3'd0;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_SH  = 3'd1;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_SW  = 3'd2;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_SBU = 3'd4;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_SHU = 3'd5;

  // Wide enough for up to four cores.
  localparam int CORE_IDX_W    = 2;
  localparam int DEFAULT_DEPTH = 256;

  // Byte-lane write mask. The low two size bits select byte/half/word, so
  // the unsigned load encodings decode the same as their signed twins.
  function automatic logic [3:0] size_mask(input logic [MEM_TYPE_WIDTH-1:0] sz,
                                           input logic [1:0] off);
    logic [3:0] m;
    case (sz[1:0])
      2'd0:    m = 4'b0001 << off;
      2'd1:    m = off[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Halfwords must be 2-byte aligned, words 4-byte aligned.
  function automatic logic size_misaligned(input logic [MEM_TYPE_WIDTH-1:0] sz,
                                           input logic [1:0] off);
    logic bad;
    case (sz[1:0])
      2'd0:    bad = 1'b0;
      2'd1:    bad = off[0];
      default: bad = (off != 2'd0);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/vscale_dmem_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after the
// last-grant pointer (wrapping modulo N) and reports the new pointer. The
// pointer register itself lives in the parent.
module vscale_rr_arbiter
  import vscale_dmem_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req_i,
  input  logic [CORE_IDX_W-1:0] last_grant_i,
  output logic [N-1:0]          grant_o,
  output logic [CORE_IDX_W-1:0] next_ptr_o
);

  logic [CORE_IDX_W-1:0] idx;
  logic                  found;

  // Scan from last_grant+1 around the ring; first requester wins.
  always_comb begin
    grant_o    = '0;
    next_ptr_o = last_grant_i;
    found      = 1'b0;
    idx        = '0;
    for (int off = 1; off <= N; off++) begin
      idx = CORE_IDX_W'((int'(last_grant_i) + off) % N);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        next_ptr_o   = idx;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vscale_dmem_arbiter.sv
// Data-memory responder shared by NCORES vscale pipelines. One access per
// cycle is granted round-robin in the request cycle; the response cycle
// returns read data combinationally from the word RAM, raises wait on
// losers and badmem on out-of-range or misaligned accesses, and commits
// the masked store at the end of the response cycle.
// Optional per-core lost-arbitration counters: VSCALE_DMEM_ARB_STATS_EN.
module vscale_dmem_arbiter
  import vscale_dmem_arbiter_pkg::*;
#(
  parameter int NCORES = 4,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NCORES-1:0]                core_dmem_en,
  input  logic [NCORES-1:0]                core_dmem_wen,
  input  logic [NCORES*MEM_TYPE_WIDTH-1:0] core_dmem_size,
  input  logic [NCORES*XPR_LEN-1:0]        core_dmem_addr,
  input  logic [NCORES*XPR_LEN-1:0]        core_dmem_wdata_delayed,
  output logic [NCORES-1:0]                core_dmem_wait,
  output logic [NCORES*XPR_LEN-1:0]        core_dmem_rdata,
  output logic [NCORES-1:0]                core_dmem_badmem_e,
  output logic [NCORES*16-1:0]             conflict_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [XPR_LEN-1:0] ADDR_LIMIT = XPR_LEN'(DEPTH * 4);

  logic [NCORES-1:0]         grant;
  logic [CORE_IDX_W-1:0]     arb_ptr;

  logic [CORE_IDX_W-1:0]     last_grant_q;
  logic                      resp_valid_q,  resp_valid_d;
  logic [CORE_IDX_W-1:0]     resp_core_q,   resp_core_d;
  logic [XPR_LEN-1:0]        resp_addr_q,   resp_addr_d;
  logic [MEM_TYPE_WIDTH-1:0] resp_size_q,   resp_size_d;
  logic                      resp_wen_q,    resp_wen_d;
  logic [NCORES-1:0]         lost_q,        lost_d;

  logic [XPR_LEN-1:0]        mem_q [DEPTH];

  logic [AW-1:0]             widx;
  logic                      resp_bad;
  logic                      wr_en;
  logic [3:0]                wr_mask;
  logic [XPR_LEN-1:0]        wdata_sel;
  logic [XPR_LEN-1:0]        rd_word;

  vscale_rr_arbiter #(.N(NCORES)) u_rr (
    .req_i        (core_dmem_en),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .next_ptr_o   (arb_ptr)
  );

  // Request cycle: capture the granted core's request and who lost.
  always_comb begin
    resp_valid_d = |grant;
    resp_core_d  = arb_ptr;
    resp_addr_d  = '0;
    resp_size_d  = '0;
    resp_wen_d   = 1'b0;
    lost_d       = core_dmem_en & ~grant;
    for (int c = 0; c < NCORES; c++) begin
      if (grant[c]) begin
        resp_addr_d = core_dmem_addr[c*XPR_LEN +: XPR_LEN];
        resp_size_d = core_dmem_size[c*MEM_TYPE_WIDTH +: MEM_TYPE_WIDTH];
        resp_wen_d  = core_dmem_wen[c];
      end
    end
  end

  // Request-to-response pipeline registers and the round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= CORE_IDX_W'(NCORES - 1);
      resp_valid_q <= 1'b0;
      resp_core_q  <= '0;
      resp_addr_q  <= '0;
      resp_size_q  <= '0;
      resp_wen_q   <= 1'b0;
      lost_q       <= '0;
    end else begin
      if (|grant) last_grant_q <= arb_ptr;
      resp_valid_q <= resp_valid_d;
      resp_core_q  <= resp_core_d;
      resp_addr_q  <= resp_addr_d;
      resp_size_q  <= resp_size_d;
      resp_wen_q   <= resp_wen_d;
      lost_q       <= lost_d;
    end
  end

  // Response cycle: validate the access, read the word, pick the store data.
  always_comb begin
    widx      = resp_addr_q[AW+1:2];
    resp_bad  = resp_valid_q &
                ((resp_addr_q >= ADDR_LIMIT) ||
                 size_misaligned(resp_size_q, resp_addr_q[1:0]));
    wr_en     = resp_valid_q & resp_wen_q & ~resp_bad;
    wr_mask   = size_mask(resp_size_q, resp_addr_q[1:0]);
    rd_word   = mem_q[widx];
    wdata_sel = '0;
    for (int c = 0; c < NCORES; c++) begin
      if (resp_core_q == CORE_IDX_W'(c))
        wdata_sel = core_dmem_wdata_delayed[c*XPR_LEN +: XPR_LEN];
    end
  end

  // Per-core response outputs; only the granted core sees data or an error.
  always_comb begin
    core_dmem_wait     = lost_q;
    core_dmem_rdata    = '0;
    core_dmem_badmem_e = '0;
    for (int c = 0; c < NCORES; c++) begin
      if (resp_valid_q && resp_core_q == CORE_IDX_W'(c)) begin
        core_dmem_rdata[c*XPR_LEN +: XPR_LEN] = resp_bad ? '0 : rd_word;
        core_dmem_badmem_e[c]                 = resp_bad;
      end
    end
  end

  // Masked store commits at the end of the response cycle; RAM has no reset,
  // and an in-flight write is dropped because reset clears resp_valid_q.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) mem_q[widx][b*8 +: 8] <= wdata_sel[b*8 +: 8];
      end
    end
  end

`ifdef VSCALE_DMEM_ARB_STATS_EN
  logic [15:0] cnt_q [NCORES];
  logic [15:0] cnt_d [NCORES];

  // Saturating count of cycles each core spent waiting on arbitration.
  always_comb begin
    for (int c = 0; c < NCORES; c++) begin
      cnt_d[c] = cnt_q[c];
      if (lost_q[c] && cnt_q[c] != 16'hFFFF) cnt_d[c] = cnt_q[c] + 16'd1;
      conflict_cnt[c*16 +: 16] = cnt_q[c];
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NCORES; c++) cnt_q[c] <= '0;
    end else begin
      for (int c = 0; c < NCORES; c++) cnt_q[c] <= cnt_d[c];
    end
  end
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_vscale_dmem_arbiter.sv
// Directed testbench for vscale_dmem_arbiter (4 cores, DEPTH 256).
module tb_vscale_dmem_arbiter;

  localparam logic [2:0] SB = 3'd0;
  localparam logic [2:0] SH = 3'd1;
  localparam logic [2:0] SW = 3'd2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [3:0]   en = '0;
  logic [3:0]   wen = '0;
  logic [11:0]  size = '0;
  logic [127:0] addr = '0;
  logic [127:0] wdata = '0;
  logic [3:0]   dwait;
  logic [127:0] rdata;
  logic [3:0]   badmem;
  logic [63:0]  cnt;

  int total = 0;
  int bad = 0;

  vscale_dmem_arbiter #(.NCORES(4), .DEPTH(256)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .core_dmem_en            (en),
    .core_dmem_wen           (wen),
    .core_dmem_size          (size),
    .core_dmem_addr          (addr),
    .core_dmem_wdata_delayed (wdata),
    .core_dmem_wait          (dwait),
    .core_dmem_rdata         (rdata),
    .core_dmem_badmem_e      (badmem),
    .conflict_cnt            (cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  // One isolated access by core c: request cycle, then response cycle with
  // store data; returns the response seen by that core. Starts and ends 1ns
  // after a rising edge.
  task automatic access(input int c, input logic w, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic wt, output logic bd);
    en[c] = 1'b1; wen[c] = w; size[c*3 +: 3] = sz; addr[c*32 +: 32] = a;
    @(posedge clk); #1;
    en[c] = 1'b0; wdata[c*32 +: 32] = wd;
    @(negedge clk);
    rd = rdata[c*32 +: 32]; wt = dwait[c]; bd = badmem[c];
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (dwait !== 4'h0) begin bad++; $display("FAIL reset_wait got=%h exp=0", dwait); end
    total++; if (rdata !== 128'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    total++; if (badmem !== 4'h0) begin bad++; $display("FAIL reset_badmem got=%h exp=0", badmem); end
    total++; if (cnt !== 64'h0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", cnt); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    int waits [4];
    logic [3:0] exp_w;
    for (int c = 0; c < 4; c++) begin
      waits[c] = 0;
      size[c*3 +: 3] = SW; wen[c] = 1'b0; addr[c*32 +: 32] = 32'h100 + 32'(4*c);
    end
    en = 4'hF;
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_w = ~(4'b0001 << (i % 4));
      total++; if (dwait !== exp_w) begin bad++; $display("FAIL rr_wait cycle=%0d got=%b exp=%b", i, dwait, exp_w); end
      total++; if (badmem !== 4'h0) begin bad++; $display("FAIL rr_badmem cycle=%0d got=%b exp=0", i, badmem); end
      for (int c = 0; c < 4; c++) if (dwait[c] === 1'b1) waits[c]++;
      @(posedge clk);
    end
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      total++; if (waits[c] != 6) begin bad++; $display("FAIL rr_wait_count core=%0d got=%0d exp=6", c, waits[c]); end
`ifdef VSCALE_DMEM_ARB_STATS_EN
      total++; if (cnt[c*16 +: 16] !== 16'd6) begin bad++; $display("FAIL rr_cnt core=%0d got=%0d exp=6", c, cnt[c*16 +: 16]); end
`else
      total++; if (cnt[c*16 +: 16] !== 16'd0) begin bad++; $display("FAIL rr_cnt core=%0d got=%0d exp=0", c, cnt[c*16 +: 16]); end
`endif
    end
    @(posedge clk); #1;
    en = 4'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic wt, bd;
    access(0, 1'b1, SW, 32'h10, 32'hDEADBEEF, rd, wt, bd);
    total++; if (wt !== 1'b0) begin bad++; $display("FAIL wr_wait got=%b exp=0", wt); end
    total++; if (bd !== 1'b0) begin bad++; $display("FAIL wr_badmem got=%b exp=0", bd); end
    en[0] = 1'b1; wen[0] = 1'b0; size[2:0] = SW; addr[31:0] = 32'h10;
    @(posedge clk); #1;
    en[0] = 1'b0;
    @(negedge clk);
    total++; if (rdata[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h exp=deadbeef", rdata[31:0]); end
    total++; if (rdata[127:32] !== 96'h0) begin bad++; $display("FAIL rd_other_rdata got=%h exp=0", rdata[127:32]); end
    total++; if (dwait !== 4'h0) begin bad++; $display("FAIL rd_wait got=%b exp=0", dwait); end
    total++; if (badmem !== 4'h0) begin bad++; $display("FAIL rd_badmem got=%b exp=0", badmem); end
    @(posedge clk); #1;
  endtask

  task automatic test_byte_store();
    logic [31:0] rd; logic wt, bd;
    access(1, 1'b1, SW, 32'h10, 32'h11223344, rd, wt, bd);
    access(1, 1'b1, SB, 32'h13, 32'h5A5A5A5A, rd, wt, bd);
    total++; if (bd !== 1'b0) begin bad++; $display("FAIL sb_badmem got=%b exp=0", bd); end
    access(1, 1'b0, SW, 32'h10, 32'h0, rd, wt, bd);
    total++; if (rd !== 32'h5A223344) begin bad++; $display("FAIL sb_read got=%h exp=5a223344", rd); end
    access(1, 1'b1, SB, 32'h10, 32'h99999999, rd, wt, bd);
    access(1, 1'b0, SW, 32'h10, 32'h0, rd, wt, bd);
    total++; if (rd !== 32'h5A223399) begin bad++; $display("FAIL sb_lane0 got=%h exp=5a223399", rd); end
  endtask

  task automatic test_badmem();
    logic [31:0] rd; logic wt, bd;
    access(2, 1'b1, SW, 32'h0, 32'h01234567, rd, wt, bd);
    access(2, 1'b1, SW, 32'h400, 32'hFFFFFFFF, rd, wt, bd);
    total++; if (bd !== 1'b1) begin bad++; $display("FAIL bad_oor_write got=%b exp=1", bd); end
    total++; if (wt !== 1'b0) begin bad++; $display("FAIL bad_oor_wait got=%b exp=0", wt); end
    access(2, 1'b1, SW, 32'h402, 32'hEEEEEEEE, rd, wt, bd);
    total++; if (bd !== 1'b1) begin bad++; $display("FAIL bad_402 got=%b exp=1", bd); end
    access(2, 1'b0, SW, 32'h400, 32'h0, rd, wt, bd);
    total++; if (bd !== 1'b1) begin bad++; $display("FAIL bad_oor_read got=%b exp=1", bd); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL bad_oor_rdata got=%h exp=0", rd); end
    access(2, 1'b0, SW, 32'h0, 32'h0, rd, wt, bd);
    total++; if (rd !== 32'h01234567) begin bad++; $display("FAIL bad_oor_unchanged got=%h exp=01234567", rd); end
    total++; if (bd !== 1'b0) begin bad++; $display("FAIL bad_word0_badmem got=%b exp=0", bd); end
    access(2, 1'b1, SW, 32'h20, 32'hCAFEF00D, rd, wt, bd);
    access(2, 1'b1, SH, 32'h21, 32'hBEEFBEEF, rd, wt, bd);
    total++; if (bd !== 1'b1) begin bad++; $display("FAIL bad_sh_misalign got=%b exp=1", bd); end
    access(2, 1'b0, SW, 32'h20, 32'h0, rd, wt, bd);
    total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL bad_sh_unchanged got=%h exp=cafef00d", rd); end
    access(2, 1'b1, SH, 32'h22, 32'h77887788, rd, wt, bd);
    total++; if (bd !== 1'b0) begin bad++; $display("FAIL sh_aligned_badmem got=%b exp=0", bd); end
    access(2, 1'b0, SW, 32'h20, 32'h0, rd, wt, bd);
    total++; if (rd !== 32'h7788F00D) begin bad++; $display("FAIL sh_upper got=%h exp=7788f00d", rd); end
    access(2, 1'b1, SW, 32'h21, 32'h12345678, rd, wt, bd);
    total++; if (bd !== 1'b1) begin bad++; $display("FAIL bad_sw_misalign got=%b exp=1", bd); end
  endtask

  task automatic test_reset_midwrite();
    logic [31:0] rd; logic wt, bd;
    access(0, 1'b1, SW, 32'h30, 32'h11111111, rd, wt, bd);
    en[0] = 1'b1; wen[0] = 1'b1; size[2:0] = SW; addr[31:0] = 32'h30;
    @(posedge clk); #1;
    en[0] = 1'b0; wdata[31:0] = 32'h22222222;
    #1;
    total++; if (rdata[31:0] !== 32'h11111111) begin bad++; $display("FAIL rst_pre_rdata got=%h exp=11111111", rdata[31:0]); end
    reset_n = 1'b0;
    #1;
    total++; if (rdata !== 128'h0) begin bad++; $display("FAIL rst_mid_rdata got=%h exp=0", rdata); end
    total++; if (dwait !== 4'h0 || badmem !== 4'h0) begin bad++; $display("FAIL rst_mid_ctrl got=%b/%b exp=0/0", dwait, badmem); end
    total++; if (cnt !== 64'h0) begin bad++; $display("FAIL rst_mid_cnt got=%h exp=0", cnt); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    access(0, 1'b0, SW, 32'h30, 32'h0, rd, wt, bd);
    total++; if (rd !== 32'h11111111) begin bad++; $display("FAIL rst_write_dropped got=%h exp=11111111", rd); end
    // Core 3 has just become the pointer's owner only if it won; after a
    // single core-0 grant, the 0/3 tie goes to 3 next, so re-reset first.
    reset_n = 1'b0;
    #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    en = 4'b1001; wen = 4'b0000; size[2:0] = SW; size[11:9] = SW;
    addr[31:0] = 32'h30; addr[127:96] = 32'h30;
    @(posedge clk); #1;
    en[0] = 1'b0;
    @(negedge clk);
    total++; if (dwait !== 4'b1000) begin bad++; $display("FAIL tie_wait got=%b exp=1000", dwait); end
    total++; if (rdata[31:0] !== 32'h11111111) begin bad++; $display("FAIL tie_rdata0 got=%h exp=11111111", rdata[31:0]); end
    @(posedge clk); #1;
    en[3] = 1'b0;
    @(negedge clk);
    total++; if (dwait !== 4'b0000) begin bad++; $display("FAIL tie_retry_wait got=%b exp=0000", dwait); end
    total++; if (rdata[127:96] !== 32'h11111111) begin bad++; $display("FAIL tie_rdata3 got=%h exp=11111111", rdata[127:96]); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    en[3] = 1'b1; wen[3] = 1'b1; size[11:9] = SW; addr[127:96] = 32'h40;
    @(posedge clk); #1;
    wen[3] = 1'b0; wdata[127:96] = 32'hA5A50F0F;
    @(negedge clk);
    total++; if (dwait[3] !== 1'b0 || badmem[3] !== 1'b0) begin bad++; $display("FAIL b2b_write_resp got=%b/%b exp=0/0", dwait[3], badmem[3]); end
    @(posedge clk); #1;
    en[3] = 1'b0;
    @(negedge clk);
    total++; if (rdata[127:96] !== 32'hA5A50F0F) begin bad++; $display("FAIL b2b_read got=%h exp=a5a50f0f", rdata[127:96]); end
    total++; if (dwait[3] !== 1'b0) begin bad++; $display("FAIL b2b_read_wait got=%b exp=0", dwait[3]); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_write_read();
    test_byte_store();
    test_badmem();
    test_reset_midwrite();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
